fetch_unit: RTL and testbench

- Instruction fetch stage feeding the cpu decode/execute path.
- Owns the program counter and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Buffers returned instructions with their PCs in a small prefetch FIFO.
- Presents them to decode over valid/ready; a taken branch/jump redirect flushes the buffer and restarts fetch.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 96 +++++++++
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, reset PC,
// fetch FSM states and the prefetch entry layout.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_INSTR_W = 16;

    localparam logic [DEF_ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with synchronous flush, occupancy count and a registered
// head so the consumer sees flop outputs that hold while not popped.
module fetch_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] remain;
    logic             head_valid_q, head_valid_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             pop_ok;
    logic             wr_en;

    // Next pointers, occupancy and head; the head is the pushed word when
    // nothing else survives the pop, so a push into an empty FIFO is
    // visible right after the same edge.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        wr_en        = 1'b0;
        pop_ok       = pop & head_valid_q;
        remain       = count_q - CNT_W'(pop_ok);
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d      = remain + CNT_W'(push);
            head_valid_d = (count_d != '0);
            if (remain == '0) begin
                if (push) begin
                    head_data_d = push_data;
                end
            end else begin
                head_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage array; contents need no reset since validity lives in count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Control and head registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    assign count      = count_q;
    assign head_valid = head_valid_q;
    assign head_data  = head_data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem
// request at a time, buffers results in a prefetch FIFO and hands them to
// decode. A redirect flushes the buffer and restarts fetch at the target.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned INSTR_W    = DEF_INSTR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_flushed
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    fetch_state_e              state_q, state_d;
    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic [ADDR_W-1:0]         target_q, target_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      req_q, req_d;
    logic                      ack;
    logic                      push;
    logic [CNT_W-1:0]          fifo_count;
    logic [ADDR_W+INSTR_W-1:0] head_data;

    fetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_data  ({pc_q, imem_rdata}),
        .pop        (dec_ready),
        .count      (fifo_count),
        .head_valid (dec_valid),
        .head_data  (head_data)
    );

    assign {dec_pc, dec_instr} = head_data;
    assign ack       = req_q & imem_ack;
    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    // Fetch sequencing: request issue, response capture and redirect
    // handling including the drop of a response already in flight.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        addr_d   = addr_q;
        req_d    = req_q;
        push     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (fifo_count < DEPTH_C) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    if (ack) begin
                        pc_d    = redirect_pc;
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        target_d = redirect_pc;
                        state_d  = ST_DROP;
                    end
                end else if (ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + PC_ONE;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (ack) begin
                    pc_d    = redirect ? redirect_pc : target_q;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (redirect) begin
                    target_d = redirect_pc;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, PC and registered request outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= ADDR_W'(RESET_PC);
            target_q <= '0;
            addr_q   <= '0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0]      fetched_q, fetched_d;
    logic [15:0]      flushed_q, flushed_d;
    logic [16:0]      fetched_sum, flushed_sum;
    logic [CNT_W-1:0] flush_entries;
    logic             pop_ok;
    logic             drop_resp;

    // Saturating counts; entries popped in the redirect cycle were
    // delivered, so only the remainder counts as flushed.
    always_comb begin
        pop_ok        = dec_valid & dec_ready;
        drop_resp     = ack & ((state_q == ST_DROP) | ((state_q == ST_WAIT) & redirect));
        flush_entries = redirect ? (fifo_count - CNT_W'(pop_ok)) : '0;
        fetched_sum   = {1'b0, fetched_q} + 17'(push);
        flushed_sum   = {1'b0, flushed_q} + 17'(flush_entries) + 17'(drop_resp);
        fetched_d     = fetched_sum[16] ? '1 : fetched_sum[15:0];
        flushed_d     = flushed_sum[16] ? '1 : flushed_sum[15:0];
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized memory latency, decode
// back-pressure and redirects against a queue-based reference model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned IW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req, imem_ack;
    logic [AW-1:0] imem_addr, redirect_pc, dec_pc;
    logic [IW-1:0] imem_rdata, dec_instr;
    logic          redirect, dec_valid, dec_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]   perf_fetched, perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W     (AW),
        .INSTR_W    (IW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents and response behaviour.
    logic [IW-1:0] mem [256];
    int unsigned   mcnt     = 0;
    int unsigned   lat      = 1;
    bit            rand_lat = 0;
    bit            spur     = 0;

    // Stimulus policy.
    int unsigned   ready_pct  = 100;
    int unsigned   redir_pct  = 0;
    int unsigned   rmode      = 0;   // 1: with ack, 2: in-flight without ack, 3: now
    logic [AW-1:0] rtarget    = '0;
    bit            rst_on_req = 0;

    // Reference model: program counter, request, drop flag and a queue.
    fetch_entry_t  mq[$];
    fetch_entry_t  xq[$];
    bit            m_req, m_drop, m_dv;
    logic [AW-1:0] m_addr, m_pc, m_tgt, m_dpc;
    logic [IW-1:0] m_di;
    int unsigned   m_fetched, m_flushed;

    function automatic logic [15:0] sat16(input int unsigned v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    task automatic model_step();
        int unsigned  occ;
        bit           pop, ack;
        fetch_entry_t e;
        if (!rst_n) begin
            mq.delete();
            m_req = 0; m_drop = 0; m_dv = 0;
            m_addr = '0; m_pc = '0; m_tgt = '0; m_dpc = '0; m_di = '0;
            m_fetched = 0; m_flushed = 0;
            return;
        end
        occ = mq.size();
        pop = m_dv && dec_ready;
        ack = m_req && imem_ack;
        if (pop) void'(mq.pop_front());
        if (redirect) begin
            m_flushed += mq.size();
            mq.delete();
            if (!m_req) begin
                m_pc = redirect_pc;
            end else if (ack) begin
                m_req = 0; m_drop = 0; m_pc = redirect_pc;
                m_flushed++;
            end else begin
                m_drop = 1; m_tgt = redirect_pc;
            end
        end else if (m_req) begin
            if (ack) begin
                m_req = 0;
                if (m_drop) begin
                    m_drop = 0; m_pc = m_tgt;
                    m_flushed++;
                end else begin
                    e.pc = m_pc; e.instr = imem_rdata;
                    mq.push_back(e);
                    m_pc = m_pc + 8'd1;
                    m_fetched++;
                end
            end
        end else if (occ < DEPTH) begin
            m_req = 1; m_addr = m_pc;
        end
        if (mq.size() > 0) begin
            m_dv = 1; m_dpc = mq[0].pc; m_di = mq[0].instr;
        end else begin
            m_dv = 0;
        end
    endtask

    task automatic check_outputs();
        check_eq("imem_req", imem_req, m_req);
        if (m_req) check_eq("imem_addr", imem_addr, m_addr);
        check_eq("dec_valid", dec_valid, m_dv);
        check_eq("dec_pc", dec_pc, m_dpc);
        check_eq("dec_instr", dec_instr, m_di);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetched", perf_fetched, sat16(m_fetched));
        check_eq("perf_flushed", perf_flushed, sat16(m_flushed));
`endif
    endtask

    // One clock: compare at the falling edge, drive inputs, advance the model.
    task automatic tick();
        fetch_entry_t e;
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        if (rst_on_req && imem_req) begin
            rst_n = 1'b0;
            rst_on_req = 0;
        end
        if (imem_req) begin
            if (rand_lat && mcnt == 0) lat = $urandom_range(3, 1);
            imem_ack   = (mcnt >= lat - 1);
            imem_rdata = imem_ack ? mem[imem_addr] : IW'($urandom);
            mcnt       = imem_ack ? 0 : mcnt + 1;
        end else begin
            mcnt       = 0;
            imem_ack   = spur && ($urandom_range(3) == 0);
            imem_rdata = IW'($urandom);
        end
        if (!rst_n) mcnt = 0;
        dec_ready   = ($urandom_range(99) < ready_pct);
        redirect    = 1'b0;
        redirect_pc = AW'($urandom_range(255));
        if (rst_n) begin
            if ((rmode == 1 && imem_req && imem_ack) ||
                (rmode == 2 && imem_req && !imem_ack) || rmode == 3) begin
                redirect = 1'b1; redirect_pc = rtarget; rmode = 0;
            end else if (rmode == 0 && $urandom_range(99) < redir_pct) begin
                redirect = 1'b1;
            end
        end
        if (rst_n && dec_valid && dec_ready) begin
            e.pc = dec_pc; e.instr = dec_instr;
            xq.push_back(e);
        end
        if (redirect || !rst_n) xq.delete();
        @(posedge clk);
        model_step();
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic expect_xfer(input string tag, input int unsigned idx,
                               input logic [AW-1:0] pc, input logic [IW-1:0] instr);
        if (idx >= xq.size()) begin
            check_eq({tag, "_count"}, xq.size(), idx + 1);
        end else begin
            check_eq({tag, "_pc"}, xq[idx].pc, pc);
            check_eq({tag, "_instr"}, xq[idx].instr, instr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
        mem[0] = 16'h1001; mem[1] = 16'h2002; mem[2] = 16'h3003;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_dec_valid", dec_valid, 0);
        check_eq("rst_dec_pc", dec_pc, 0);
        check_eq("rst_dec_instr", dec_instr, 0);

        // Straight-line fetch with a single-cycle memory.
        run(12);
        expect_xfer("seq0", 0, 8'h00, 16'h1001);
        expect_xfer("seq1", 1, 8'h01, 16'h2002);
        expect_xfer("seq2", 2, 8'h02, 16'h3003);

        // Decode stalled: FIFO fills and requests stop.
        ready_pct = 0;
        run(20);
        #1;
        check_eq("full_no_req", imem_req, 0);
        check_eq("full_valid", dec_valid, 1);
        ready_pct = 100;
        run(12);

        // Redirect while a 3-cycle request is in flight.
        lat = 3; rtarget = 8'h40; rmode = 2;
        run(24);
        expect_xfer("drop40", 0, 8'h40, mem[8'h40]);

        // Redirect coincident with the ack.
        lat = 1; rtarget = 8'h10; rmode = 1;
        run(12);
        expect_xfer("ackredir", 0, 8'h10, mem[8'h10]);

        // PC wrap from 0xFF to 0x00.
        rtarget = 8'hFE; rmode = 3;
        run(14);
        expect_xfer("wrap0", 0, 8'hFE, mem[8'hFE]);
        expect_xfer("wrap1", 1, 8'hFF, mem[8'hFF]);
        expect_xfer("wrap2", 2, 8'h00, 16'h1001);

        // Reset during an outstanding request.
        lat = 3; rst_on_req = 1;
        run(16);
        expect_xfer("rst_restart", 0, 8'h00, 16'h1001);

        // Randomized traffic.
        rand_lat = 1; spur = 1; ready_pct = 70; redir_pct = 5;
        run(1500);
        ready_pct = 20; redir_pct = 3;
        run(800);
        ready_pct = 100; redir_pct = 10;
        run(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
